// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding and Mem port widths.
package prog_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STATE_W = 3;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  function automatic logic in_frame(input state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_WRITE) ||
           (s == S_CHECK) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Saturating idle timer: reloads on clear, counts down while enabled, flags at zero.
module loader_timeout #(
  parameter int W = 24,
  parameter logic [W-1:0] LIMIT = W'(5_000_000)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= LIMIT;
    end else if (clear) begin
      cnt <= LIMIT;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that assembles little-endian words into Mem and starts the core.
//   state   | meaning
//   IDLE    | waiting for header, other bytes dropped
//   LEN     | next byte is word count (0 = 256)
//   DATA    | collecting payload bytes into the word assembler
//   WRITE   | one-cycle Mem write strobe, input stalled
//   CHECK   | next byte is the XOR checksum
//   DONE    | one-cycle start pulse to the core
//   ERR     | bad frame, sticky error until a new header
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd0,
  parameter logic [23:0]       TIMEOUT   = 24'd5_000_000,
  parameter logic [7:0]        HEADER    = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              loading,
  output logic              start,
  output logic              error,
  output logic [8:0]        words_loaded
);

  state_t      state, state_nxt;
  logic        accept;
  logic        cnt_en;
  logic        tmo_expired;
  logic [8:0]  remaining;
  logic [1:0]  byte_idx;
  logic [7:0]  chk;
  logic [23:0] word_asm;

  assign accept = rx_valid && rx_ready;
  assign start  = (state == S_DONE);

  loader_timeout #(
    .W     (24),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (cnt_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      S_IDLE, S_ERR: begin
        rx_ready = 1'b1;
        if (rx_valid && (rx_data == HEADER)) state_nxt = S_LEN;
      end
      S_LEN: begin
        rx_ready = 1'b1;
        cnt_en   = 1'b1;
        if (rx_valid)         state_nxt = S_DATA;
        else if (tmo_expired) state_nxt = S_ERR;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        cnt_en   = 1'b1;
        if (rx_valid) begin
          if (byte_idx == 2'd3) state_nxt = S_WRITE;
        end else if (tmo_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_WRITE: begin
        state_nxt = (remaining == 9'd1) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        rx_ready = 1'b1;
        cnt_en   = 1'b1;
        if (rx_valid)         state_nxt = (rx_data == chk) ? S_DONE : S_ERR;
        else if (tmo_expired) state_nxt = S_ERR;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      mem_address  <= BASE_ADDR;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      loading      <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      remaining    <= '0;
      byte_idx     <= '0;
      chk          <= '0;
      word_asm     <= '0;
    end else begin
      state    <= state_nxt;
      mem_wren <= (state_nxt == S_WRITE);
      // Held one extra cycle past DONE so the core's port mux releases after start.
      loading  <= in_frame(state_nxt) || (state == S_DONE);
      if (state_nxt == S_ERR) error <= 1'b1;

      unique case (state)
        S_LEN: begin
          if (accept) begin
            remaining    <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            chk          <= '0;
            byte_idx     <= '0;
            words_loaded <= '0;
            mem_address  <= BASE_ADDR;
            error        <= 1'b0;
          end
        end
        S_DATA: begin
          if (accept) begin
            chk      <= chk ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_asm[7:0]   <= rx_data;
              2'd1: word_asm[15:8]  <= rx_data;
              2'd2: word_asm[23:16] <= rx_data;
              default: mem_data     <= {rx_data, word_asm};
            endcase
          end
        end
        S_WRITE: begin
          mem_address  <= mem_address + 1'b1;
          words_loaded <= words_loaded + 9'd1;
          remaining    <= remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with a synchronous Mem model.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        loading;
  logic        start;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          start_cnt = 0;
  logic [31:0] payload [$];

  prog_loader #(
    .BASE_ADDR (8'h80),
    .TIMEOUT   (24'd16),
    .HEADER    (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .loading      (loading),
    .start        (start),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) begin
      mem[mem_address] <= mem_data;
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data);
    end
    if (start) start_cnt <= start_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 40) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: rx_ready stuck %b, needed 1", rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic bad);
    logic [7:0] c;
    c = 8'h00;
    send_byte(8'hA5);
    send_byte(n);
    foreach (payload[i]) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(payload[i][8*j +: 8]);
        c = c ^ payload[i][8*j +: 8];
      end
    end
    send_byte(bad ? ~c : c);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({mem_address, mem_data, mem_wren, start, error, words_loaded, rx_ready, loading} !==
        {8'h80, 32'h0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: addr=%h data=%h wren=%b start=%b err=%b wl=%0d rdy=%b ld=%b, needed 80 0 0 0 0 0 1 0",
               mem_address, mem_data, mem_wren, start, error, words_loaded, rx_ready, loading);
    end
  endtask

  task automatic test_one_word;
    int w0, s0;
    w0 = wr_addr.size(); s0 = start_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if ({mem_wren, mem_address, mem_data, rx_ready} !== {1'b1, 8'h80, 32'h00000013, 1'b0}) begin
      errors++;
      $display("FAIL one_word_write: wren=%b addr=%h data=%h rdy=%b, needed 1 80 00000013 0",
               mem_wren, mem_address, mem_data, rx_ready);
    end
    send_byte(8'h13);
    rx_valid = 1'b0;
    checks++;
    if (start !== 1'b1 || loading !== 1'b1) begin
      errors++;
      $display("FAIL one_word_start: start=%b loading=%b, needed 1 1", start, loading);
    end
    @(posedge clk); #1;
    checks++;
    if (start !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL one_word_after_start: start=%b loading=%b, needed 0 1", start, loading);
    end
    @(posedge clk); #1;
    checks++;
    if (loading !== 1'b0 || words_loaded !== 9'd1 || error !== 1'b0) begin
      errors++;
      $display("FAIL one_word_end: loading=%b wl=%0d err=%b, needed 0 1 0", loading, words_loaded, error);
    end
    checks++;
    if (wr_addr.size() - w0 != 1 || start_cnt - s0 != 1 || mem[8'h80] !== 32'h00000013) begin
      errors++;
      $display("FAIL one_word_counts: writes=%0d starts=%0d mem80=%h, needed 1 1 00000013",
               wr_addr.size() - w0, start_cnt - s0, mem[8'h80]);
    end
  endtask

  task automatic test_bad_chk;
    int w0, s0;
    w0 = wr_addr.size(); s0 = start_cnt;
    payload = '{32'h00000013};
    send_frame(8'h01, 1'b1);
    checks++;
    if (error !== 1'b1 || start_cnt - s0 != 0 || wr_addr.size() - w0 != 1 || words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL bad_chk: err=%b starts=%0d writes=%0d wl=%0d, needed 1 0 1 1",
               error, start_cnt - s0, wr_addr.size() - w0, words_loaded);
    end
    send_byte(8'h55);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b1 || loading !== 1'b0) begin
      errors++;
      $display("FAIL err_discard: err=%b loading=%b, needed 1 0", error, loading);
    end
    s0 = start_cnt;
    payload = '{32'h12345678};
    send_frame(8'h01, 1'b0);
    checks++;
    if (error !== 1'b0 || start_cnt - s0 != 1 || mem[8'h80] !== 32'h12345678) begin
      errors++;
      $display("FAIL err_recover: err=%b starts=%0d mem80=%h, needed 0 1 12345678",
               error, start_cnt - s0, mem[8'h80]);
    end
  endtask

  task automatic test_full_256;
    int w0, s0;
    logic [7:0] ea;
    logic [7:0] iv;
    w0 = wr_addr.size(); s0 = start_cnt;
    payload = {};
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      payload.push_back({8'hC3, 8'h5A ^ iv, ~iv, iv});
    end
    send_frame(8'h00, 1'b0);
    checks++;
    if (wr_addr.size() - w0 != 256 || words_loaded !== 9'd256 || start_cnt - s0 != 1 || error !== 1'b0) begin
      errors++;
      $display("FAIL full_summary: writes=%0d wl=%0d starts=%0d err=%b, needed 256 256 1 0",
               wr_addr.size() - w0, words_loaded, start_cnt - s0, error);
    end else begin
      for (int j = 0; j < 256; j++) begin
        ea = 8'(8'h80 + j);
        checks++;
        if (wr_addr[w0 + j] !== ea || wr_data[w0 + j] !== payload[j]) begin
          errors++;
          $display("FAIL full_write_%0d: addr=%h data=%h, needed %h %h",
                   j, wr_addr[w0 + j], wr_data[w0 + j], ea, payload[j]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int w0;
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    rx_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b loading=%b, needed 0 1", error, loading);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1 || loading !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: err=%b loading=%b rdy=%b, needed 1 0 1", error, loading, rx_ready);
    end
    w0 = wr_addr.size();
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h00); send_byte(8'h01);
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1 || loading !== 1'b0 || wr_addr.size() != w0) begin
      errors++;
      $display("FAIL timeout_discard: err=%b loading=%b writes=%0d, needed 1 0 0",
               error, loading, wr_addr.size() - w0);
    end
    payload = '{32'hCAFE0001};
    send_frame(8'h01, 1'b0);
    checks++;
    if (error !== 1'b0 || mem[8'h80] !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL timeout_recover: err=%b mem80=%h, needed 0 cafe0001", error, mem[8'h80]);
    end
  endtask

  task automatic test_streaming;
    logic [7:0] fb [15];
    logic [31:0] wv [3];
    logic [7:0] c;
    int p, cyc, w0, s0;
    logic acc, prev4, exp_rdy;
    wv = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    fb[0] = 8'hA5; fb[1] = 8'h03;
    c = 8'h00;
    for (int i = 0; i < 12; i++) begin
      fb[2 + i] = wv[i / 4][8 * (i % 4) +: 8];
      c = c ^ fb[2 + i];
    end
    fb[14] = c;
    w0 = wr_addr.size(); s0 = start_cnt;
    p = 0; cyc = 0; prev4 = 1'b0;
    while (p < 15 && cyc < 60) begin
      rx_data  = fb[p];
      rx_valid = 1'b1;
      exp_rdy  = !prev4;
      if (p >= 2) begin
        checks++;
        if (rx_ready !== exp_rdy) begin
          errors++;
          $display("FAIL stream_ready_byte%0d: rdy=%b, needed %b", p, rx_ready, exp_rdy);
        end
      end
      acc = rx_ready;
      @(posedge clk); #1;
      cyc++;
      prev4 = acc && (p >= 2) && (p <= 13) && (((p - 2) % 4) == 3);
      if (acc) p++;
    end
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (p != 15 || cyc != 18) begin
      errors++;
      $display("FAIL stream_cycles: bytes=%0d cycles=%0d, needed 15 18", p, cyc);
    end
    checks++;
    if (wr_addr.size() - w0 != 3 || start_cnt - s0 != 1 ||
        mem[8'h80] !== wv[0] || mem[8'h81] !== wv[1] || mem[8'h82] !== wv[2]) begin
      errors++;
      $display("FAIL stream_data: writes=%0d starts=%0d m80=%h m81=%h m82=%h, needed 3 1 %h %h %h",
               wr_addr.size() - w0, start_cnt - s0, mem[8'h80], mem[8'h81], mem[8'h82],
               wv[0], wv[1], wv[2]);
    end
  endtask

  task automatic test_reset_midframe;
    int w0;
    w0 = wr_addr.size();
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
    send_byte(8'h77);
    rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_address, mem_data, mem_wren, start, error, words_loaded, rx_ready, loading} !==
        {8'h80, 32'h0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: addr=%h data=%h wren=%b start=%b err=%b wl=%0d rdy=%b ld=%b, needed 80 0 0 0 0 0 1 0",
               mem_address, mem_data, mem_wren, start, error, words_loaded, rx_ready, loading);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() - w0 != 2 || mem[8'h80] !== 32'hDEADBEEF ||
        mem[8'h81] !== 32'h0BADF00D || mem[8'h82] !== 32'h99AABBCC || loading !== 1'b0) begin
      errors++;
      $display("FAIL midframe_mem: writes=%0d m80=%h m81=%h m82=%h ld=%b, needed 2 deadbeef 0badf00d 99aabbcc 0",
               wr_addr.size() - w0, mem[8'h80], mem[8'h81], mem[8'h82], loading);
    end
  endtask

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_one_word();
    test_bad_chk();
    test_full_256();
    test_timeout();
    test_streaming();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
